// File: rtl/lfsr_div9_pkg.sv
// Shared definitions for the XNOR-LFSR clock divider and its upstream mapper.
// Holds the FSM states, the special LFSR values and the feedback tap mask.
package lfsr_div9_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StExtra
  } state_e;

  // Predecessor of 8'h00 in the XNOR sequence; reaching it ends a period.
  localparam logic [7:0] TERM     = 8'h80;
  // All-ones is the XNOR lockup state and is never loaded.
  localparam logic [7:0] LOCKUP   = 8'hFF;
  // Feedback taps on bits 7, 5, 4, 3.
  localparam logic [7:0] TAP_MASK = 8'hB8;

endpackage

// File: rtl/lfsr8_xnor_step.sv
// One step of the 8-bit shift-left XNOR LFSR.
// Purely combinational; also instantiated by the upstream seed mapper.
module lfsr8_xnor_step
  import lfsr_div9_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {cur[6:0], ~^(cur & TAP_MASK)};

endmodule

// File: rtl/lfsr_div9.sv
// Programmable clock divider: counts an XNOR LFSR from a seed to TERM, with an
// optional extra cycle, emitting a tick and toggling div_out once per period.
module lfsr_div9
  import lfsr_div9_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] dp,
  input  logic       done,
  output logic       tick,
  output logic       div_out,
  output logic       running,
  output logic       err,
  output logic [7:0] lfsr
);

  state_e     state_q;
  logic [8:0] shadow_q;
  logic       ext_q;
  logic       done_q;
  logic       armed_q;

  logic       rise;
  logic       seed_ok;
  logic [8:0] reload_src;
  logic [7:0] lfsr_step;

  lfsr8_xnor_step u_step (
    .cur (lfsr),
    .nxt (lfsr_step)
  );

  // armed_q blocks a done level held across reset from looking like an edge.
  assign rise       = done & ~done_q & armed_q;
  assign seed_ok    = (dp[8:1] != LOCKUP);
  // An edge landing on the reload cycle must win over the stale shadow.
  assign reload_src = rise ? dp : shadow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      lfsr     <= 8'h00;
      shadow_q <= 9'h000;
      ext_q    <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
      tick     <= 1'b0;
      div_out  <= 1'b0;
      running  <= 1'b0;
      err      <= 1'b0;
    end else begin
      done_q <= done;
      if (!done) armed_q <= 1'b1;
      tick <= 1'b0;
      if (rise) shadow_q <= dp;

      if (rise && !seed_ok) begin
        err     <= 1'b1;
        state_q <= StIdle;
        running <= 1'b0;
      end else begin
        if (rise) err <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              lfsr    <= dp[8:1];
              ext_q   <= dp[0];
              state_q <= StRun;
              running <= 1'b1;
            end
          end
          StRun: begin
            if (lfsr != TERM) begin
              lfsr <= lfsr_step;
            end else if (!ext_q) begin
              tick    <= 1'b1;
              div_out <= ~div_out;
              lfsr    <= reload_src[8:1];
              ext_q   <= reload_src[0];
            end else begin
              // ext_q belongs to the current period, so a mid-period dp
              // change cannot lengthen or shorten it.
              state_q <= StExtra;
            end
          end
          StExtra: begin
            tick    <= 1'b1;
            div_out <= ~div_out;
            lfsr    <= reload_src[8:1];
            ext_q   <= reload_src[0];
            state_q <= StRun;
          end
          default: begin
            state_q <= StIdle;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_div9.sv
// Self-checking bench for lfsr_div9: a period-counting reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_lfsr_div9;

  logic       clock;
  logic       reset;
  logic [8:0] dp;
  logic       done;
  logic       tick;
  logic       div_out;
  logic       running;
  logic       err;
  logic [7:0] lfsr;

  int checks   = 0;
  int failures = 0;

  lfsr_div9 dut (
    .clock   (clock),
    .reset   (reset),
    .dp      (dp),
    .done    (done),
    .tick    (tick),
    .div_out (div_out),
    .running (running),
    .err     (err),
    .lfsr    (lfsr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: tracks position within the current period rather than
  // any FSM state; expected LFSR value is derived from the seed and position.
  typedef struct packed {
    logic        run;
    logic [7:0]  seed;
    logic        ext;
    int unsigned pos;
    logic [8:0]  shadow;
    logic        err;
    logic        div;
    logic        tick;
    logic        prev;
    logic        armed;
    logic [7:0]  lfsr;
  } model_t;

  model_t m;

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

  function automatic int unsigned steps_to_term(input logic [7:0] seed);
    logic [7:0]  s = seed;
    int unsigned k = 0;
    while (s != 8'h80 && k < 300) begin
      s = step8(s);
      k++;
    end
    return k;
  endfunction

  function automatic int unsigned period_of(input logic [7:0] seed, input logic ext);
    return steps_to_term(seed) + 1 + {31'd0, ext};
  endfunction

  function automatic logic [7:0] lfsr_at(input logic [7:0] seed, input int unsigned pos);
    logic [7:0] s = seed;
    if (pos > steps_to_term(seed)) return 8'h80;
    for (int i = 0; i < int'(pos); i++) s = step8(s);
    return s;
  endfunction

  function automatic model_t model_next(input model_t c, input logic d, input logic [8:0] p);
    model_t n    = c;
    logic   rise = d && !c.prev && c.armed;
    n.tick = 1'b0;
    n.prev = d;
    if (!d) n.armed = 1'b1;
    if (rise) n.shadow = p;
    if (rise && p[8:1] == 8'hFF) begin
      n.err = 1'b1;
      n.run = 1'b0;
    end else begin
      if (rise) n.err = 1'b0;
      if (!c.run) begin
        if (rise) begin
          n.run  = 1'b1;
          n.seed = p[8:1];
          n.ext  = p[0];
          n.pos  = 0;
        end
      end else if (c.pos == period_of(c.seed, c.ext) - 1) begin
        n.tick = 1'b1;
        n.div  = ~c.div;
        n.seed = n.shadow[8:1];
        n.ext  = n.shadow[0];
        n.pos  = 0;
      end else begin
        n.pos = c.pos + 1;
      end
      if (n.run) n.lfsr = lfsr_at(n.seed, n.pos);
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_next(m, done, dp);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model tick",    {31'd0, tick},    {31'd0, m.tick});
    check("model div_out", {31'd0, div_out}, {31'd0, m.div});
    check("model running", {31'd0, running}, {31'd0, m.run});
    check("model err",     {31'd0, err},     {31'd0, m.err});
    check("model lfsr",    {24'd0, lfsr},    {24'd0, m.lfsr});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pulse_done(input logic [8:0] v);
    dp   = v;
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    done  = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic count_ticks(input int n, output int cnt, output int tog);
    logic last = div_out;
    cnt = 0;
    tog = 0;
    repeat (n) begin
      @(negedge clock);
      if (tick) cnt++;
      if (div_out != last) tog++;
      last = div_out;
    end
  endtask

  int cnt, tog;

  initial begin
    reset = 1'b1;
    done  = 1'b0;
    dp    = 9'h000;
    cyc(2);
    @(negedge clock);
    check("reset running", {31'd0, running}, 32'd0);
    check("reset lfsr",    {24'd0, lfsr},    32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Seed at TERM, no extension: tick every cycle.
    pulse_done(9'h100);
    @(negedge clock);
    check("p1 start lfsr", {24'd0, lfsr}, 32'h80);
    check("p1 start tick", {31'd0, tick}, 32'd0);
    count_ticks(8, cnt, tog);
    check("p1 ticks", cnt, 8);
    check("p1 toggles", tog, 8);

    // Seed C0 with extension: C0, 80, 80(extra), then tick every 3.
    do_reset();
    pulse_done(9'h181);
    @(negedge clock);
    check("c0x lfsr0", {24'd0, lfsr}, 32'hC0);
    @(negedge clock);
    check("c0x lfsr1", {24'd0, lfsr}, 32'h80);
    @(negedge clock);
    check("c0x lfsr2", {24'd0, lfsr}, 32'h80);
    check("c0x extra tick", {31'd0, tick}, 32'd0);
    @(negedge clock);
    check("c0x tick", {31'd0, tick}, 32'd1);
    check("c0x reload", {24'd0, lfsr}, 32'hC0);
    count_ticks(9, cnt, tog);
    check("c0x ticks", cnt, 3);

    // Seed 60: period 3, then a mid-period switch to period 1.
    do_reset();
    pulse_done(9'h0C0);
    @(negedge clock);
    check("s60 lfsr0", {24'd0, lfsr}, 32'h60);
    @(negedge clock);
    check("s60 lfsr1", {24'd0, lfsr}, 32'hC0);
    @(negedge clock);
    check("s60 lfsr2", {24'd0, lfsr}, 32'h80);
    cyc(2);
    pulse_done(9'h100);
    cyc(4);
    count_ticks(5, cnt, tog);
    check("s60 then p1 ticks", cnt, 5);

    // Lockup seed rejected, then a valid seed clears err.
    do_reset();
    pulse_done(9'h1FE);
    @(negedge clock);
    check("lock err", {31'd0, err}, 32'd1);
    check("lock running", {31'd0, running}, 32'd0);
    count_ticks(5, cnt, tog);
    check("lock ticks", cnt, 0);
    cyc(1);
    pulse_done(9'h100);
    @(negedge clock);
    check("unlock err", {31'd0, err}, 32'd0);
    check("unlock running", {31'd0, running}, 32'd1);
    count_ticks(4, cnt, tog);
    check("unlock ticks", cnt, 4);

    // Reset two cycles before a tick; done held high afterwards.
    do_reset();
    pulse_done(9'h181);
    cyc(4);
    reset = 1'b1;
    done  = 1'b1;
    @(negedge clock);
    check("abort tick", {31'd0, tick}, 32'd0);
    check("abort running", {31'd0, running}, 32'd0);
    check("abort div", {31'd0, div_out}, 32'd0);
    check("abort lfsr", {24'd0, lfsr}, 32'd0);
    cyc(2);
    reset = 1'b0;
    count_ticks(10, cnt, tog);
    check("held done ticks", cnt, 0);
    check("held done running", {31'd0, running}, 32'd0);
    cyc(1);
    done = 1'b0;

    // New dp arriving on the reload cycle takes effect immediately.
    do_reset();
    pulse_done(9'h100);
    cyc(3);
    pulse_done(9'h181);
    check("edge reload tick", {31'd0, tick}, 32'd1);
    check("edge reload lfsr", {24'd0, lfsr}, 32'hC0);
    count_ticks(6, cnt, tog);
    check("edge reload ticks", cnt, 2);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
